// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index and a hold limit
// that pre-empts a long-running owner while others wait.
module rr_arbiter_8 #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             found;
  logic [IDX_W-1:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    found   = 1'b0;
    sel     = '0;

    // Rotating priority scan: ptr has highest priority, ptr-1 (mod 8) lowest.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[ptr_q + IDX_W'(i)]) begin
        found = 1'b1;
        sel   = ptr_q + IDX_W'(i);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (en && found) begin
          state_d    = StGrant;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          idx_d      = sel;
          ptr_d      = sel + IDX_W'(1);
          hold_d     = '0;
        end
      end
      StGrant: begin
        // A drop of req[g] and a hold-limit pre-emption release identically.
        if (!req[idx_q] || (hold_q == HoldLast && |(req & ~gnt_q))) begin
          state_d = StRelease;
          gnt_d   = '0;
          idx_d   = '0;
          hold_d  = '0;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 8'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt     = gnt_q;
    gnt_idx = idx_q;
    gnt_vld = |gnt_q;
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: a vector table for basic/en/wrap behaviour plus
// hand-written sequences for fairness, hold limit, no-competition and async reset.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       en;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  int checks;
  int errors;

  rr_arbiter_8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] ei,
                     input logic ev);
    checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev) begin
      errors++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b, expected gnt=%h idx=%0d vld=%b",
               name, gnt, gnt_idx, gnt_vld, eg, ei, ev);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    step();
    chk("reset", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ptr starts at 0; each row shows the state after the edge that samples it.
    vecs[0]  = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1};  // ptr -> 1
    vecs[1]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};  // release
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};  // dead cycle -> idle
    vecs[3]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[4]  = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};  // ptr -> 3
    vecs[5]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[7]  = '{8'h44, 1'b0, 8'h00, 3'd0, 1'b0};  // en low blocks
    vecs[8]  = '{8'h44, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[9]  = '{8'h44, 1'b1, 8'h40, 3'd6, 1'b1};  // scan from 3 -> 6, ptr -> 7
    vecs[10] = '{8'h44, 1'b0, 8'h40, 3'd6, 1'b1};  // en low keeps grant
    vecs[11] = '{8'h44, 1'b0, 8'h40, 3'd6, 1'b1};
    vecs[12] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0};  // req[6] drops
    vecs[13] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[14] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[15] = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};  // scan from 7 -> 2, ptr -> 3
    vecs[16] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[17] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[18] = '{8'h81, 1'b1, 8'h80, 3'd7, 1'b1};  // 7 wins over 0, ptr wraps to 0
    vecs[19] = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0};  // release
    vecs[20] = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0};  // mandatory dead cycle ignores req
    vecs[21] = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1};
    vecs[22] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[23] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 24; i++) begin
      req = vecs[i].req;
      en  = vecs[i].en;
      step();
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld);
    end

    // Fairness: all requesting, each owner drops after 2 granted cycles.
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      logic [7:0] oh;
      e  = 3'(k % 8);
      oh = 8'h01 << e;
      step();
      chk($sformatf("fair%0d_gnt", k), oh, e, 1'b1);
      step();
      chk($sformatf("fair%0d_hold", k), oh, e, 1'b1);
      req = 8'hFF & ~oh;
      step();
      chk($sformatf("fair%0d_rel", k), 8'h00, 3'd0, 1'b0);
      req = 8'hFF;
      step();
      chk($sformatf("fair%0d_dead", k), 8'h00, 3'd0, 1'b0);
    end

    // Hold limit: ptr is 1, requester 0 alone, then 5 joins at grant cycle 5.
    req = 8'h01;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1);
      if (c == 5) req = 8'h21;
    end
    step();
    chk("hold_release", 8'h00, 3'd0, 1'b0);
    step();
    chk("hold_dead", 8'h00, 3'd0, 1'b0);
    step();
    chk("hold_next", 8'h20, 3'd5, 1'b1);

    // No competition: ptr is 6, only requester 3.
    req = 8'h08;
    step();
    chk("nocomp_rel", 8'h00, 3'd0, 1'b0);
    step();
    chk("nocomp_dead", 8'h00, 3'd0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step();
      chk($sformatf("nocomp_c%0d", c), 8'h08, 3'd3, 1'b1);
    end

    // Async reset mid-grant: ptr is 4, requester 4 alone.
    req = 8'h10;
    step();
    chk("arst_rel", 8'h00, 3'd0, 1'b0);
    step();
    chk("arst_dead", 8'h00, 3'd0, 1'b0);
    step();
    chk("arst_gnt", 8'h10, 3'd4, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_immediate", 8'h00, 3'd0, 1'b0);
    step();
    chk("arst_held", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'hFF;
    en    = 1'b1;
    step();
    chk("arst_ptr0", 8'h01, 3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
